// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sample chain: serial frame layout, transmitter
// state encoding and width helpers.
package dds_pkg;

  localparam int unsigned SampleW    = 10;
  localparam int unsigned FramePadHi = 4;
  localparam int unsigned FramePadLo = 2;
  localparam int unsigned FrameLen   = FramePadHi + SampleW + FramePadLo;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StShift = 2'd2,
    StHold  = 2'd3
  } tx_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles,
// synchronous clear restarts the count.
module spi_bit_timer
  import dds_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CntMax);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one offset-adjusted sample per start strobe into a zero-padded
// SPI frame for an external DAC; all outputs come straight from flops.
module dac_spi_tx
  import dds_pkg::*;
#(
  parameter int unsigned DW      = SampleW,
  parameter int unsigned PAD_HI  = FramePadHi,
  parameter int unsigned PAD_LO  = FramePadLo,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] data_in,
  output logic          cs_n,
  output logic          sclk,
  output logic          sdo,
  output logic          busy,
  output logic          done,
  output logic          ovr
);

  localparam int unsigned FrameW = PAD_HI + DW + PAD_LO;
  localparam int unsigned BitW   = cnt_width(FrameW);
  localparam int unsigned HoldW  = cnt_width(CS_HOLD);
  localparam logic [BitW-1:0]  BitMax  = BitW'(FrameW - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(CS_HOLD - 1);

  tx_state_e          state_q, state_d;
  logic [FrameW-1:0]  shreg_q, shreg_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               cs_n_q, cs_n_d, sclk_q, sclk_d, sdo_q, sdo_d;
  logic               busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic               timer_en, timer_clr, tick;
  logic [FrameW-1:0]  frame;

  assign frame = FrameW'(data_in) << PAD_LO;

  spi_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (timer_en),
    .clr  (timer_clr),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    hold_d    = hold_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    ovr_d     = start && (state_q != StIdle);
    timer_clr = 1'b0;
    timer_en  = (state_q == StSetup) || (state_q == StShift);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d   = frame;
          sdo_d     = frame[FrameW-1];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_d     = '0;
          hold_d    = '0;
          timer_clr = 1'b1;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: present the next bit while sclk is low.
            sclk_d  = 1'b0;
            shreg_d = shreg_q << 1;
            sdo_d   = shreg_q[FrameW-2];
          end else if (bit_q == BitMax) begin
            cs_n_d  = 1'b1;
            sdo_d   = 1'b0;
            hold_d  = '0;
            state_d = StHold;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (hold_q == HoldMax) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered done lands on the final hold cycle.
    done_d = (state_d == StHold) && (hold_d == HoldMax);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign sdo  = sdo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovr  = ovr_q;

endmodule
